// File: rtl/sram_dma_writer.sv
// Avalon-MM write master: drains 64-bit SRAM words as two 32-bit beats (high half first).
// Optional XOR checksum of accepted beats is enabled by defining DMA_XOR_SUM_EN.
module sram_dma_writer #(
   parameter int MASTER_ADDRESSWIDTH = 26,
   parameter int DATAWIDTH           = 32,
   parameter int ADDRSIZE            = 14,
   parameter int SRAMWIDTH           = 64,
   parameter int SRAM_RD_LAT         = 2
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic [MASTER_ADDRESSWIDTH-1:0] base_address,
   input  logic [ADDRSIZE-1:0]            sram_start_addr,
   input  logic [ADDRSIZE-1:0]            word_count,
   output logic                           busy,
   output logic                           done,
   output logic [ADDRSIZE-1:0]            words_sent,
   output logic [DATAWIDTH-1:0]           xor_sum,
   output logic [ADDRSIZE-1:0]            sram_addr,
   output logic                           sram_rden,
   input  logic [SRAMWIDTH-1:0]           sram_q,
   output logic [MASTER_ADDRESSWIDTH-1:0] master_address,
   output logic [DATAWIDTH-1:0]           master_writedata,
   output logic                           master_write,
   input  logic                           master_waitrequest
);

   typedef enum logic [2:0] {
      S_IDLE, S_RD, S_WAIT, S_WR_HI, S_WR_LO, S_FIN
   } state_t;

   state_t                         state, state_nxt;
   logic [MASTER_ADDRESSWIDTH-1:0] byte_addr;
   logic [ADDRSIZE-1:0]            sram_ptr;
   logic [ADDRSIZE-1:0]            word_total;
   logic [ADDRSIZE-1:0]            sent_cnt;
   logic [SRAMWIDTH-1:0]           word_hold;
   logic [2:0]                     lat_cnt;
   logic                           beat_ok;
   logic                           lat_done;
   logic                           last_word;

   assign beat_ok   = master_write && !master_waitrequest;
   assign lat_done  = (lat_cnt == 3'(SRAM_RD_LAT));
   assign last_word = (ADDRSIZE'(sent_cnt + 1'b1) == word_total);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // NOTE: every signal gets a default before the case so no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = (word_count == '0) ? S_FIN : S_RD;
         S_RD:    state_nxt = S_WAIT;
         S_WAIT:  if (lat_done) state_nxt = S_WR_HI;
         S_WR_HI: if (beat_ok) state_nxt = S_WR_LO;
         S_WR_LO: if (beat_ok) state_nxt = last_word ? S_FIN : S_RD;
         S_FIN:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Bus outputs are driven from held registers, so they stay frozen while waitrequest is high.
   always_comb begin
      busy             = (state != S_IDLE) && (state != S_FIN);
      done             = (state == S_FIN);
      sram_rden        = (state == S_RD);
      sram_addr        = sram_ptr;
      words_sent       = sent_cnt;
      master_write     = 1'b0;
      master_address   = '0;
      master_writedata = '0;
      if (state == S_WR_HI) begin
         master_write     = 1'b1;
         master_address   = byte_addr;
         master_writedata = word_hold[SRAMWIDTH-1:DATAWIDTH];
      end else if (state == S_WR_LO) begin
         master_write     = 1'b1;
         master_address   = byte_addr + MASTER_ADDRESSWIDTH'(4);
         master_writedata = word_hold[DATAWIDTH-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         byte_addr  <= '0;
         sram_ptr   <= '0;
         word_total <= '0;
         sent_cnt   <= '0;
         word_hold  <= '0;
         lat_cnt    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  byte_addr  <= base_address;
                  sram_ptr   <= sram_start_addr;
                  word_total <= word_count;
                  sent_cnt   <= '0;
               end
            end
            S_RD: lat_cnt <= 3'd1;
            S_WAIT: begin
               if (lat_done) word_hold <= sram_q;
               else          lat_cnt   <= lat_cnt + 3'd1;
            end
            S_WR_LO: begin
               // Pointer and address widths give the required modulo wrap for free.
               if (beat_ok) begin
                  byte_addr <= byte_addr + MASTER_ADDRESSWIDTH'(8);
                  sram_ptr  <= sram_ptr + 1'b1;
                  sent_cnt  <= sent_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef DMA_XOR_SUM_EN
   logic [DATAWIDTH-1:0] xor_acc;

   always_ff @(posedge clk) begin
      if (reset)                          xor_acc <= '0;
      else if (state == S_IDLE && start)  xor_acc <= '0;
      else if (beat_ok)                   xor_acc <= xor_acc ^ master_writedata;
   end

   assign xor_sum = xor_acc;
`else
   assign xor_sum = '0;
`endif

endmodule

// File: tb/tb_sram_dma_writer.sv
// Directed self-checking bench for sram_dma_writer with a 2-cycle-latency SRAM model.
// Works with or without DMA_XOR_SUM_EN defined.
module tb_sram_dma_writer;

   localparam int AW  = 26;
   localparam int DW  = 32;
   localparam int SA  = 14;
   localparam int SW  = 64;
   localparam int LAT = 2;

   logic          clk;
   logic          reset;
   logic          start;
   logic [AW-1:0] base_address;
   logic [SA-1:0] sram_start_addr;
   logic [SA-1:0] word_count;
   logic          busy;
   logic          done;
   logic [SA-1:0] words_sent;
   logic [DW-1:0] xor_sum;
   logic [SA-1:0] sram_addr;
   logic          sram_rden;
   logic [SW-1:0] sram_q;
   logic [AW-1:0] master_address;
   logic [DW-1:0] master_writedata;
   logic          master_write;
   logic          master_waitrequest;

   sram_dma_writer #(
      .MASTER_ADDRESSWIDTH(AW), .DATAWIDTH(DW), .ADDRSIZE(SA),
      .SRAMWIDTH(SW), .SRAM_RD_LAT(LAT)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .base_address(base_address),
      .sram_start_addr(sram_start_addr), .word_count(word_count), .busy(busy),
      .done(done), .words_sent(words_sent), .xor_sum(xor_sum), .sram_addr(sram_addr),
      .sram_rden(sram_rden), .sram_q(sram_q), .master_address(master_address),
      .master_writedata(master_writedata), .master_write(master_write),
      .master_waitrequest(master_waitrequest)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM model: data appears LAT cycles after the rden cycle and then holds.
   logic [SW-1:0] mem [0:(1<<SA)-1];
   logic [SW-1:0] pipe0, pipe1;
   always @(posedge clk) begin
      if (sram_rden) pipe0 <= mem[sram_addr];
      pipe1 <= pipe0;
   end
   assign sram_q = pipe1;

   // Bus and SRAM-read monitors, sampled mid-cycle.
   logic [AW-1:0] bq_addr [$];
   logic [DW-1:0] bq_data [$];
   logic [SA-1:0] rq_addr [$];
   int            write_cycles;
   always @(negedge clk) begin
      if (master_write && !master_waitrequest) begin
         bq_addr.push_back(master_address);
         bq_data.push_back(master_writedata);
      end
      if (master_write) write_cycles++;
      if (sram_rden) rq_addr.push_back(sram_addr);
   end

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      bq_addr.delete();
      bq_data.delete();
      rq_addr.delete();
      write_cycles = 0;
   endtask

   task automatic do_start(input logic [AW-1:0] b, input logic [SA-1:0] s, input logic [SA-1:0] n);
      base_address    = b;
      sram_start_addr = s;
      word_count      = n;
      start           = 1'b1;
      tick();
      start           = 1'b0;
      base_address    = '0;
      sram_start_addr = '0;
      word_count      = '0;
   endtask

   task automatic wait_done(input int max, output int cyc);
      cyc = 0;
      for (int i = 1; i <= max; i++) begin
         tick();
         if (done === 1'b1) begin
            cyc = i;
            break;
         end
      end
      if (cyc == 0) check("wait_done_timeout", 64'(done), 64'd1);
   endtask

   task automatic expect_beat(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (i < bq_addr.size()) begin
         check($sformatf("beat%0d_addr", i), 64'(bq_addr[i]), 64'(a));
         check($sformatf("beat%0d_data", i), 64'(bq_data[i]), 64'(d));
      end else begin
         check($sformatf("beat%0d_present", i), 64'(bq_addr.size()), 64'(i + 1));
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_busy"},  64'(busy), 64'd0);
      check({tag, "_done"},  64'(done), 64'd0);
      check({tag, "_rden"},  64'(sram_rden), 64'd0);
      check({tag, "_saddr"}, 64'(sram_addr), 64'd0);
      check({tag, "_write"}, 64'(master_write), 64'd0);
      check({tag, "_maddr"}, 64'(master_address), 64'd0);
      check({tag, "_wdata"}, 64'(master_writedata), 64'd0);
      check({tag, "_sent"},  64'(words_sent), 64'd0);
      check({tag, "_xor"},   64'(xor_sum), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cyc;
      logic [DW-1:0] xor_exp4, xor_exp3;
`ifdef DMA_XOR_SUM_EN
      xor_exp4 = 32'h0000_0000;
      xor_exp3 = 32'hFFFF_FFFF;
`else
      xor_exp4 = 32'h0;
      xor_exp3 = 32'h0;
`endif
      reset = 1'b1; start = 1'b0; master_waitrequest = 1'b0;
      base_address = '0; sram_start_addr = '0; word_count = '0;
      pipe0 = '0; pipe1 = '0;
      write_cycles = 0;
      mem[5]       = 64'h0123_4567_89AB_CDEF;
      mem[7]       = 64'hCAFE_BABE_DEAD_BEEF;
      mem[(1<<SA)-1] = 64'h1111_2222_3333_4444;
      mem[0]       = 64'h5555_6666_7777_8888;
      for (int i = 0; i < 4; i++) mem[20+i] = {32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i)};
      mem[30]      = 64'h0BAD_F00D_1234_5678;
      for (int i = 0; i < 4; i++) mem[40+i] = 64'hFFFF_FFFF_0000_0000;
      // Start is held high during reset: reset must win.
      start = 1'b1; word_count = 14'd1;
      tick(); tick(); tick();
      check_zero("reset");
      start = 1'b0; word_count = '0;
      reset = 1'b0;
      tick();

      // Single word, no stall.
      clear_mon();
      do_start(26'h1000, 14'd5, 14'd1);
      check("sw_busy", 64'(busy), 64'd1);
      check("sw_rden", 64'(sram_rden), 64'd1);
      check("sw_saddr", 64'(sram_addr), 64'd5);
      tick(); tick(); tick();
      check("sw_hi_write", 64'(master_write), 64'd1);
      check("sw_hi_addr", 64'(master_address), 64'h1000);
      check("sw_hi_data", 64'(master_writedata), 64'h0123_4567);
      tick();
      check("sw_lo_addr", 64'(master_address), 64'h1004);
      check("sw_lo_data", 64'(master_writedata), 64'h89AB_CDEF);
      tick();
      check("sw_done", 64'(done), 64'd1);
      check("sw_fin_busy", 64'(busy), 64'd0);
      check("sw_sent", 64'(words_sent), 64'd1);
      tick();
      check("sw_done_pulse", 64'(done), 64'd0);
      check("sw_beats", 64'(bq_addr.size()), 64'd2);
      check("sw_reads", 64'(rq_addr.size()), 64'd1);

      // Stall on the high beat for three cycles.
      clear_mon();
      master_waitrequest = 1'b1;
      do_start(26'h2000, 14'd7, 14'd1);
      tick(); tick(); tick();
      for (int i = 0; i < 4; i++) begin
         if (i == 3) master_waitrequest = 1'b0;
         check($sformatf("st_write_c%0d", i), 64'(master_write), 64'd1);
         check($sformatf("st_addr_c%0d", i), 64'(master_address), 64'h2000);
         check($sformatf("st_data_c%0d", i), 64'(master_writedata), 64'hCAFE_BABE);
         tick();
      end
      check("st_lo_addr", 64'(master_address), 64'h2004);
      check("st_lo_data", 64'(master_writedata), 64'hDEAD_BEEF);
      tick();
      check("st_done", 64'(done), 64'd1);
      check("st_beats", 64'(bq_addr.size()), 64'd2);
      expect_beat(0, 26'h2000, 32'hCAFE_BABE);
      expect_beat(1, 26'h2004, 32'hDEAD_BEEF);
      tick();

      // Zero length; a start during FIN is ignored.
      clear_mon();
      do_start(26'h3000, 14'd9, 14'd0);
      check("zl_done", 64'(done), 64'd1);
      check("zl_busy", 64'(busy), 64'd0);
      check("zl_sent", 64'(words_sent), 64'd0);
      do_start(26'h3000, 14'd9, 14'd1);
      check("zl_fin_start_busy", 64'(busy), 64'd0);
      check("zl_fin_start_done", 64'(done), 64'd0);
      tick(); tick(); tick();
      check("zl_reads", 64'(rq_addr.size()), 64'd0);
      check("zl_writes", 64'(write_cycles), 64'd0);

      // Wrap of SRAM pointer and byte address.
      clear_mon();
      do_start(26'h3FF_FFF8, 14'd16383, 14'd2);
      wait_done(40, cyc);
      check("wr_cycles", 64'(cyc), 64'd10);
      check("wr_sent", 64'(words_sent), 64'd2);
      check("wr_reads", 64'(rq_addr.size()), 64'd2);
      if (rq_addr.size() == 2) begin
         check("wr_read0", 64'(rq_addr[0]), 64'd16383);
         check("wr_read1", 64'(rq_addr[1]), 64'd0);
      end
      expect_beat(0, 26'h3FF_FFF8, 32'h1111_2222);
      expect_beat(1, 26'h3FF_FFFC, 32'h3333_4444);
      expect_beat(2, 26'h000_0000, 32'h5555_6666);
      expect_beat(3, 26'h000_0004, 32'h7777_8888);
      tick();

      // Reset during the third word's low beat, then a fresh transfer.
      clear_mon();
      do_start(26'h100, 14'd20, 14'd4);
      for (int i = 0; i < 14; i++) tick();
      check("rm_lo_write", 64'(master_write), 64'd1);
      check("rm_lo_addr", 64'(master_address), 64'h114);
      reset = 1'b1;
      tick();
      check_zero("rm");
      reset = 1'b0;
      tick();
      clear_mon();
      do_start(26'h4000, 14'd30, 14'd1);
      wait_done(20, cyc);
      check("rm_new_cycles", 64'(cyc), 64'd5);
      check("rm_new_beats", 64'(bq_addr.size()), 64'd2);
      expect_beat(0, 26'h4000, 32'h0BAD_F00D);
      expect_beat(1, 26'h4004, 32'h1234_5678);
      tick();

      // Checksum over 4 then 3 words; a start while busy is ignored.
      clear_mon();
      do_start(26'h5000, 14'd40, 14'd4);
      tick(); tick();
      do_start(26'h9000, 14'd0, 14'd1);
      wait_done(60, cyc);
      check("x4_cycles", 64'(cyc), 64'd17);
      check("x4_sent", 64'(words_sent), 64'd4);
      check("x4_beats", 64'(bq_addr.size()), 64'd8);
      expect_beat(6, 26'h5018, 32'hFFFF_FFFF);
      expect_beat(7, 26'h501C, 32'h0000_0000);
      check("x4_xor", 64'(xor_sum), 64'(xor_exp4));
      tick();
      clear_mon();
      do_start(26'h6000, 14'd40, 14'd3);
      wait_done(60, cyc);
      check("x3_cycles", 64'(cyc), 64'd15);
      check("x3_xor", 64'(xor_sum), 64'(xor_exp3));
      check("x3_beats", 64'(bq_addr.size()), 64'd6);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
